ter_lift_phi1_stream: RTL
=========================

// Module: ter_lift_phi1_stream
// PURPOSE
//  Streaming multiply-by-(x-1) stage of the poly_lift datapath, downstream of the ternary arithmetic/inverse_phi1 logic.
//  Consumes one ternary coefficient a_i per handshake, i = 0..N-1, and emits the mod-q coefficients of
//  c = (x-1)*a mod (x^N - 1).
//  Rules: c_i = a_{i-1} - a_i for i >= 1; c_0 = a_{N-1} - a_0, emitted last.
//  Output feeds the mod-q coefficient buffer of the lift result.
// PARAMETERS
//  N      701  polynomial length (coefficients per frame); must be >= 2
//  Q_W    13   output coefficient width; q = 2**Q_W
//  IDX_W  10   index width; must satisfy 2**IDX_W >= N
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      in_coef is valid
//  in_ready   out  1      block accepts in_coef this cycle
//  in_coef    in   2      ternary {sign,nz}: 00=0, 01=+1, 11=-1, 10=illegal
//  out_valid  out  1      out_coef/out_idx/out_last are valid
//  out_ready  in   1      downstream accepts output this cycle
//  out_coef   out  Q_W    c_i mod 2^Q_W, two's complement
//  out_idx    out  IDX_W  index i of out_coef
//  out_last   out  1      set with c_0, the final output of a frame
//  err_illegal out 1      sticky; set when an accepted in_coef == 2'b10
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, cnt=0, a0/prev=0, out_valid=0, out_coef=0, out_idx=0,
//    out_last=0, err_illegal=0. in_ready is combinational and reads 1 in IDLE after reset.
//  Handshakes: in transfer when in_valid&in_ready; out transfer when out_valid&out_ready.
//  Output payload stays stable while out_valid=1 and out_ready=0.
//  Output slot: single register. slot_free = !out_valid | out_ready.
//  FSM:
//   IDLE: in_ready=1. On accept: a0<=in, prev<=in, cnt<=1 -> RUN. No output produced.
//   RUN: in_ready=slot_free. On accept of a_cnt:
//     load out: coef = prev - a_cnt, idx = cnt, last = 0
//     prev<=a_cnt; cnt<=cnt+1
//     if cnt == N-1 -> WRAP
//   WRAP: in_ready=0. When slot_free:
//     load out: coef = prev - a0, idx = 0, last = 1
//     cnt<=0 -> IDLE
//  Latency: c_i is valid the cycle after a_i is accepted; c_0 is valid the cycle after WRAP finds the slot free.
//  Throughput: 1 coefficient/cycle with out_ready=1; one bubble per frame, at WRAP.
//  Simultaneous events: an out transfer and a new load in the same cycle is legal; out_valid stays 1.
//  out_valid falls only on a transfer with no new load.
//  Arithmetic: difference lies in {-2..2}, sign-extended to Q_W bits.
//    Q_W=13 encodings: 0 -> 0, +1 -> 1, +2 -> 2, -1 -> 8191, -2 -> 8190.
//  Illegal input 2'b10: treated as 0 for arithmetic; sets err_illegal (cleared only by reset).
//  in_valid deasserted mid-frame: state and cnt hold; no timeout.
//  Reset mid-frame: frame is discarded, all state returns to reset values, and any pending output is dropped.
// STRUCTURE
//  Shared package ter_pkg:
//    typedef logic [1:0] ter_t
//    constants TER_ZERO=2'b00, TER_POS=2'b01, TER_NEG=2'b11
//    function ter_to_int (returns -1/0/+1)
//    FSM enum {IDLE, RUN, WRAP}
//  Sub-module ter_sub_modq: combinational (x, y: ter_t) -> Q_W-bit (x - y) mod 2^Q_W.
//    Instantiated once; its y input is muxed between a_cnt (RUN) and a0 (WRAP).
//  Remainder: FSM, counter, a0/prev registers, output register.
// TESTING (bench with N=4, Q_W=13)
//  1 Reset: rst_n=0 mid-frame -> out_valid=0 and err_illegal=0 immediately (async); next frame decodes correctly.
//  2 Frame a=[+1,0,-1,+1], out_ready=1 -> outputs in order (idx,coef,last):
//      (1,1,0) (2,1,0) (3,8190,0) (0,0,1)
//  3 Frame a=[-1,+1,+1,-1] -> (1,8190) (2,0) (3,2) (0,0,last=1)
//  4 Same as 2, out_ready low for 3 cycles after first out_valid -> out_coef/out_idx held stable;
//      in_ready=0 while slot full; no loss or duplication.
//  5 Back-to-back frames with in_valid=1 continuous -> 8 outputs; exactly one in_ready=0 bubble per frame at WRAP.
//  6 in_coef=2'b10 at i=2 of [0,+1,10,0] -> err_illegal=1 (sticky); c_2=1, c_3=0.

Source files
------------

// File: rtl/ter_pkg.sv
// Shared ternary-coefficient types and helpers for the poly_lift datapath.
package ter_pkg;

    typedef logic [1:0] ter_t;

    localparam ter_t TER_ZERO = 2'b00;
    localparam ter_t TER_POS  = 2'b01;
    localparam ter_t TER_NEG  = 2'b11;
    localparam ter_t TER_ILL  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WRAP
    } state_t;

    // The illegal code 2'b10 decodes to 0 so it never disturbs the arithmetic.
    function automatic int ter_to_int(ter_t t);
        case (t)
            TER_POS: return 1;
            TER_NEG: return -1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/ter_lift_phi1_stream_if.sv
// Coefficient-in / mod-q-coefficient-out stream bundle for ter_lift_phi1_stream.
interface ter_lift_phi1_stream_if #(
    parameter int unsigned Q_W   = 13,
    parameter int unsigned IDX_W = 10
) ();

    logic               in_valid;
    logic               in_ready;
    ter_pkg::ter_t      in_coef;
    logic               out_valid;
    logic               out_ready;
    logic [Q_W-1:0]     out_coef;
    logic [IDX_W-1:0]   out_idx;
    logic               out_last;
    logic               err_illegal;

    modport master (
        output in_valid, in_coef, out_ready,
        input  in_ready, out_valid, out_coef, out_idx, out_last, err_illegal
    );

    modport slave (
        input  in_valid, in_coef, out_ready,
        output in_ready, out_valid, out_coef, out_idx, out_last, err_illegal
    );

endinterface

// File: rtl/ter_lift_phi1_stream_modq.sv
// Ternary difference x - y, sign-extended to a Q_W-bit mod-2^Q_W coefficient.
module ter_sub_modq
    import ter_pkg::*;
#(
    parameter int unsigned Q_W = 13
) (
    input  ter_t           x,
    input  ter_t           y,
    output logic [Q_W-1:0] d
);

    logic signed [2:0] diff3;

    always_comb begin
        diff3 = 3'(ter_to_int(x) - ter_to_int(y));
        d     = {{(Q_W-3){diff3[2]}}, diff3};
    end

endmodule

// File: rtl/ter_lift_phi1_stream.sv
// Streaming multiply-by-(x-1) mod (x^N - 1): emits c_1..c_{N-1} as inputs arrive, then c_0.
module ter_lift_phi1_stream
    import ter_pkg::*;
#(
    parameter int unsigned N     = 701,
    parameter int unsigned Q_W   = 13,
    parameter int unsigned IDX_W = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ter_lift_phi1_stream_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    ter_t             a0;
    ter_t             prev;
    ter_t             a_in;
    ter_t             y_sel;
    logic             slot_free;
    logic             accept;
    logic [Q_W-1:0]   diff;

    assign slot_free    = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state == IDLE) || ((state == RUN) && slot_free);
    assign accept       = bus.in_valid && bus.in_ready;
    assign a_in         = (bus.in_coef == TER_ILL) ? TER_ZERO : bus.in_coef;
    // One subtractor serves both RUN (prev - a_cnt) and the closing WRAP term (prev - a0).
    assign y_sel        = (state == WRAP) ? a0 : a_in;

    ter_sub_modq #(.Q_W(Q_W)) u_sub (
        .x (prev),
        .y (y_sel),
        .d (diff)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            a0              <= TER_ZERO;
            prev            <= TER_ZERO;
            bus.out_valid   <= 1'b0;
            bus.out_coef    <= '0;
            bus.out_idx     <= '0;
            bus.out_last    <= 1'b0;
            bus.err_illegal <= 1'b0;
        end else begin
            if (accept && (bus.in_coef == TER_ILL))
                bus.err_illegal <= 1'b1;

            // A load below overrides this drop, so transfer+load keeps out_valid high.
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        a0    <= a_in;
                        prev  <= a_in;
                        cnt   <= IDX_W'(1);
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        bus.out_valid <= 1'b1;
                        bus.out_coef  <= diff;
                        bus.out_idx   <= cnt;
                        bus.out_last  <= 1'b0;
                        prev          <= a_in;
                        cnt           <= cnt + IDX_W'(1);
                        if (cnt == LAST_IDX)
                            state <= WRAP;
                    end
                end
                WRAP: begin
                    if (slot_free) begin
                        bus.out_valid <= 1'b1;
                        bus.out_coef  <= diff;
                        bus.out_idx   <= '0;
                        bus.out_last  <= 1'b1;
                        cnt           <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
